// File: rtl/avalon_pkg.sv
// Shared Avalon-MM slave definitions.
//   slave_state_t : IDLE / WAIT / ACK states of the waitrequest sequencer
//   LANE_W        : bits per byte lane
//   lane_count()  : number of byte lanes for a given data width
package avalon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } slave_state_t;

  localparam int LANE_W = 8;

  function automatic int lane_count(input int data_w);
    return data_w / LANE_W;
  endfunction

endpackage

// File: rtl/avs_wait_mem_if.sv
// Avalon-MM slave port bundle for avs_wait_mem.
//   avs_s0_address     word address            (master -> slave)
//   avs_s0_read        read request            (master -> slave)
//   avs_s0_write       write request           (master -> slave)
//   avs_s0_byteenable  write byte lanes        (master -> slave)
//   avs_s0_writedata   write data              (master -> slave)
//   avs_s0_readdata    read data               (slave -> master)
//   avs_s0_waitrequest stall                   (slave -> master)
interface avs_wait_mem_if
  import avalon_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);

  logic [ADDR_W-1:0]             avs_s0_address;
  logic                          avs_s0_read;
  logic                          avs_s0_write;
  logic [lane_count(DATA_W)-1:0] avs_s0_byteenable;
  logic [DATA_W-1:0]             avs_s0_writedata;
  logic [DATA_W-1:0]             avs_s0_readdata;
  logic                          avs_s0_waitrequest;

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write,
           avs_s0_byteenable, avs_s0_writedata,
    input  avs_s0_readdata, avs_s0_waitrequest
  );

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write,
           avs_s0_byteenable, avs_s0_writedata,
    output avs_s0_readdata, avs_s0_waitrequest
  );

endinterface

// File: rtl/avs_ram_core.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port. Each byte lane is its own array so every lane maps onto a plain
// block RAM column. Contents are never cleared.
//   clk    clock
//   addr   word address (only the low bits needed for DEPTH are used)
//   we     write strobe, qualified per lane by be
//   be     byte-lane write enables
//   wdata  write data
//   re     read strobe; rdata updates on the edge where re is high
//   rdata  registered read data, held between reads
module avs_ram_core
  import avalon_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  localparam int LANES = lane_count(DATA_W),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  // Callers guarantee addr < DEPTH whenever we/re are high, so only the
  // index bits the array actually needs are used.
  logic [IDX_W-1:0] idx;
  assign idx = addr[IDX_W-1:0];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] mem_lane [DEPTH];
    logic [LANE_W-1:0] q_reg;

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        mem_lane[idx] <= wdata[gi*LANE_W +: LANE_W];
      end
      if (re) begin
        q_reg <= mem_lane[idx];
      end
    end

    assign rdata[gi*LANE_W +: LANE_W] = q_reg;
  end

endmodule

// File: rtl/avs_wait_mem.sv
// Avalon-MM slave memory with a programmable number of waitrequest cycles.
// Every transfer stalls WAIT_CYCLES cycles, completes in ACK (waitrequest
// low) and returns to IDLE, so back-to-back transfers take WAIT_CYCLES+1.
//   clk    clock, rising edge
//   reset  synchronous active-high reset (state, counter, readdata)
//   s0     Avalon-MM slave port (avs_wait_mem_if.slave)
module avs_wait_mem
  import avalon_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  avs_wait_mem_if.slave  s0
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam int LANES = lane_count(DATA_W);

  slave_state_t      state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  // Set when the last read capture hit implemented memory; readdata is the
  // RAM's registered output gated by this, which gives 0 after reset and
  // after an out-of-range read without a reset on the RAM output register.
  logic              rd_valid_reg;

  logic              req;
  logic              rd_only;
  logic              in_range;
  logic              enter_ack;
  logic              capture;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign req      = s0.avs_s0_read | s0.avs_s0_write;
  // Read+write together is treated as a write, so only a pure read captures.
  assign rd_only  = s0.avs_s0_read & ~s0.avs_s0_write;
  assign in_range = {1'b0, s0.avs_s0_address} < (ADDR_W + 1)'(DEPTH);

  // Edge that moves the FSM into ACK.
  assign enter_ack = req &&
                     (((state_reg == IDLE) && (WAIT_CYCLES == 1)) ||
                      ((state_reg == WAIT) && (cnt_reg == CNT_W'(1))));

  assign capture = ~reset & enter_ack & rd_only;
  assign ram_we  = ~reset & (state_reg == ACK) & s0.avs_s0_write & in_range;

  avs_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .addr  (s0.avs_s0_address),
    .we    (ram_we),
    .be    (s0.avs_s0_byteenable[LANES-1:0]),
    .wdata (s0.avs_s0_writedata),
    .re    (capture & in_range),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (capture) begin
        rd_valid_reg <= in_range;
      end
      case (state_reg)
        IDLE: begin
          if (req) begin
            cnt_reg   <= CNT_W'(WAIT_CYCLES - 1);
            state_reg <= (WAIT_CYCLES == 1) ? ACK : WAIT;
          end
        end
        WAIT: begin
          // A master that drops its request mid-stall abandons the transfer.
          if (!req) begin
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ACK;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ACK:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s0.avs_s0_waitrequest = req & (state_reg != ACK);
  assign s0.avs_s0_readdata    = rd_valid_reg ? ram_rdata : '0;

endmodule

// File: tb/tb_avs_wait_mem.sv
// Bench for avs_wait_mem: three instances with different wait/depth settings
//   dut 0: WAIT_CYCLES=2, DEPTH=256
//   dut 1: WAIT_CYCLES=1, DEPTH=256
//   dut 2: WAIT_CYCLES=4, DEPTH=200
module tb_avs_wait_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst_d [3];
  logic        rd_d  [3];
  logic        wr_d  [3];
  logic [7:0]  a_d   [3];
  logic [3:0]  be_d  [3];
  logic [31:0] wd_d  [3];
  logic [31:0] q_w   [3];
  logic        wreq_w[3];

  avs_wait_mem_if #(.DATA_W(32), .ADDR_W(8)) if0 ();
  avs_wait_mem_if #(.DATA_W(32), .ADDR_W(8)) if1 ();
  avs_wait_mem_if #(.DATA_W(32), .ADDR_W(8)) if2 ();

  assign if0.avs_s0_address    = a_d[0];
  assign if0.avs_s0_read       = rd_d[0];
  assign if0.avs_s0_write      = wr_d[0];
  assign if0.avs_s0_byteenable = be_d[0];
  assign if0.avs_s0_writedata  = wd_d[0];
  assign q_w[0]                = if0.avs_s0_readdata;
  assign wreq_w[0]             = if0.avs_s0_waitrequest;

  assign if1.avs_s0_address    = a_d[1];
  assign if1.avs_s0_read       = rd_d[1];
  assign if1.avs_s0_write      = wr_d[1];
  assign if1.avs_s0_byteenable = be_d[1];
  assign if1.avs_s0_writedata  = wd_d[1];
  assign q_w[1]                = if1.avs_s0_readdata;
  assign wreq_w[1]             = if1.avs_s0_waitrequest;

  assign if2.avs_s0_address    = a_d[2];
  assign if2.avs_s0_read       = rd_d[2];
  assign if2.avs_s0_write      = wr_d[2];
  assign if2.avs_s0_byteenable = be_d[2];
  assign if2.avs_s0_writedata  = wd_d[2];
  assign q_w[2]                = if2.avs_s0_readdata;
  assign wreq_w[2]             = if2.avs_s0_waitrequest;

  avs_wait_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2))
    u0 (.clk(clk), .reset(rst_d[0]), .s0(if0));
  avs_wait_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(1))
    u1 (.clk(clk), .reset(rst_d[1]), .s0(if1));
  avs_wait_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(4))
    u2 (.clk(clk), .reset(rst_d[2]), .s0(if2));

  // Reference model: memory image, held readdata and per-instance settings.
  int          wc[3] = '{2, 1, 4};
  int          dp[3] = '{256, 256, 200};
  logic [31:0] mdl[3][256];
  logic [31:0] last_q[3];

  function automatic void model_xfer(input int k, input bit rd, input bit wr,
                                     input logic [7:0] a, input logic [3:0] be,
                                     input logic [31:0] d);
    if (wr) begin
      if (int'(a) < dp[k])
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[k][a][8*i +: 8] = d[8*i +: 8];
    end else if (rd) begin
      last_q[k] = (int'(a) < dp[k]) ? mdl[k][a] : 32'h0;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit rd, input bit wr, input logic [7:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    rd_d[k] = rd; wr_d[k] = wr; a_d[k] = a; be_d[k] = be; wd_d[k] = d;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
  endtask

  // Starts at posedge+1; returns at posedge+1 of the cycle after completion
  // with the request still driven, so a following call runs back-to-back.
  task automatic xfer(input int k, input bit rd, input bit wr, input logic [7:0] a,
                      input logic [3:0] be, input logic [31:0] d,
                      output logic [31:0] q, output int lat);
    drive(k, rd, wr, a, be, d);
    lat = -1;
    q   = 32'hx;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (!wreq_w[k]) begin
        lat = n;
        q   = q_w[k];
        step();
        break;
      end
      step();
    end
    $display("xfer dut=%0d rd=%0b wr=%0b addr=%h be=%h wdata=%h q=%h lat=%0d",
             k, rd, wr, a, be, d, q, lat);
  endtask

  task automatic do_reset(input int k);
    idle(k);
    rst_d[k] = 1'b1;
    step();
    rst_d[k] = 1'b0;
    last_q[k] = 32'h0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [7:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] exp_q;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    int          lat;
    int          c0;
    logic [31:0] v;
    int          op;
    logic [7:0]  a;

    tbl[0] = '{1'b0, 1'b1, 8'h05, 4'hF, 32'hDEADBEEF, 32'h00000000};
    tbl[1] = '{1'b1, 1'b0, 8'h05, 4'h0, 32'h00000000, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b1, 8'h10, 4'hF, 32'h11223344, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 8'h10, 4'h5, 32'hAABBCCDD, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 1'b0, 8'h10, 4'h0, 32'h00000000, 32'h11BB33DD};
    tbl[5] = '{1'b0, 1'b1, 8'h05, 4'h0, 32'hFFFFFFFF, 32'h11BB33DD};
    tbl[6] = '{1'b1, 1'b0, 8'h05, 4'h0, 32'h00000000, 32'hDEADBEEF};
    tbl[7] = '{1'b1, 1'b1, 8'h01, 4'hF, 32'h0000CAFE, 32'hDEADBEEF};
    tbl[8] = '{1'b1, 1'b0, 8'h01, 4'h0, 32'h00000000, 32'h0000CAFE};

    for (int k = 0; k < 3; k++) begin
      idle(k);
      rst_d[k] = 1'b1;
    end
    repeat (3) step();
    for (int k = 0; k < 3; k++) rst_d[k] = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_q%0d", k), q_w[k], 32'h0);
      chk($sformatf("reset_wreq%0d", k), 32'(wreq_w[k]), 32'h0);
    end

    // Directed vectors on the WAIT_CYCLES=2 instance.
    for (int i = 0; i < 9; i++) begin
      xfer(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].be, tbl[i].d, q, lat);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].exp_q);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
      idle(0);
      step();
    end

    // WAIT_CYCLES=1: continuous reads cost two cycles each.
    for (int i = 0; i < 4; i++)
      xfer(1, 1'b0, 1'b1, 8'(i), 4'hF, 32'hC0DE0000 + 32'(i), q, lat);
    idle(1);
    step();
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b1, 1'b0, 8'(i), 4'h0, 32'h0, q, lat);
      chk($sformatf("b2b%0d_q", i), q, 32'hC0DE0000 + 32'(i));
      chk($sformatf("b2b%0d_lat", i), 32'(lat), 32'd1);
    end
    chk("b2b_cycles", 32'(cyc - c0), 32'd8);
    idle(1);
    step();

    // DEPTH=200: out-of-range write dropped, read gives 0.
    xfer(2, 1'b0, 1'b1, 8'h70, 4'hF, 32'h01234567, q, lat);
    idle(2); step();
    xfer(2, 1'b0, 1'b1, 8'hF0, 4'hF, 32'hFFFFFFFF, q, lat);
    chk("oor_wr_lat", 32'(lat), 32'd4);
    idle(2); step();
    xfer(2, 1'b1, 1'b0, 8'h70, 4'h0, 32'h0, q, lat);
    chk("oor_pre_q", q, 32'h01234567);
    idle(2); step();
    xfer(2, 1'b1, 1'b0, 8'hF0, 4'h0, 32'h0, q, lat);
    chk("oor_rd_q", q, 32'h0);
    chk("oor_rd_lat", 32'(lat), 32'd4);
    idle(2); step();
    xfer(2, 1'b1, 1'b0, 8'h70, 4'h0, 32'h0, q, lat);
    chk("oor_70_q", q, 32'h01234567);
    idle(2); step();

    // Reset during wait cycle 2 aborts the write.
    xfer(2, 1'b0, 1'b1, 8'h20, 4'hF, 32'hA5A5A5A5, q, lat);
    idle(2); step();
    xfer(2, 1'b1, 1'b0, 8'h20, 4'h0, 32'h0, q, lat);
    chk("rw_pre_q", q, 32'hA5A5A5A5);
    idle(2); step();
    drive(2, 1'b0, 1'b1, 8'h20, 4'hF, 32'h12345678);
    step();
    step();
    rst_d[2] = 1'b1;
    step();
    rst_d[2] = 1'b0;
    #1;
    chk("rw_wreq_follows", 32'(wreq_w[2]), 32'h1);
    chk("rw_q_zero", q_w[2], 32'h0);
    idle(2);
    #1;
    chk("rw_wreq_idle", 32'(wreq_w[2]), 32'h0);
    step();
    xfer(2, 1'b1, 1'b0, 8'h20, 4'h0, 32'h0, q, lat);
    chk("rw_nocommit_q", q, 32'hA5A5A5A5);
    chk("rw_full_lat", 32'(lat), 32'd4);
    idle(2); step();

    // Reset during ACK also blocks the commit.
    xfer(2, 1'b0, 1'b1, 8'h21, 4'hF, 32'h0BADF00D, q, lat);
    idle(2); step();
    drive(2, 1'b0, 1'b1, 8'h21, 4'hF, 32'h55555555);
    repeat (4) step();
    #1;
    chk("ra_in_ack", 32'(wreq_w[2]), 32'h0);
    rst_d[2] = 1'b1;
    step();
    rst_d[2] = 1'b0;
    idle(2);
    step();
    xfer(2, 1'b1, 1'b0, 8'h21, 4'h0, 32'h0, q, lat);
    chk("ra_nocommit_q", q, 32'h0BADF00D);
    idle(2); step();

    // Request dropped mid-wait: readdata held, next transfer waits in full.
    xfer(2, 1'b1, 1'b0, 8'h20, 4'h0, 32'h0, q, lat);
    idle(2); step();
    drive(2, 1'b1, 1'b0, 8'h21, 4'h0, 32'h0);
    step();
    idle(2);
    step();
    step();
    chk("drop_q_held", q_w[2], 32'hA5A5A5A5);
    xfer(2, 1'b1, 1'b0, 8'h21, 4'h0, 32'h0, q, lat);
    chk("drop_next_lat", 32'(lat), 32'd4);
    chk("drop_next_q", q, 32'h0BADF00D);
    idle(2); step();

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3; k++) begin
      do_reset(k);
      chk($sformatf("rnd%0d_reset_q", k), q_w[k], 32'h0);
      for (int i = 0; i < 32; i++) begin
        v = $urandom;
        xfer(k, 1'b0, 1'b1, 8'(i), 4'hF, v, q, lat);
        model_xfer(k, 1'b0, 1'b1, 8'(i), 4'hF, v);
      end
      idle(k); step();
      for (int i = 0; i < 40; i++) begin
        op = $urandom_range(0, 3);
        if (k == 2 && $urandom_range(0, 3) == 0) a = 8'($urandom_range(200, 255));
        else a = 8'($urandom_range(0, 31));
        v = $urandom;
        xfer(k, op != 2, op >= 2, a, 4'($urandom_range(0, 15)), v, q, lat);
        model_xfer(k, op != 2, op >= 2, a, be_d[k], v);
        chk($sformatf("rnd%0d_%0d_q", k, i), q, last_q[k]);
        chk($sformatf("rnd%0d_%0d_lat", k, i), 32'(lat), 32'(wc[k]));
        if ($urandom_range(0, 1) == 1) begin
          idle(k);
          step();
        end
      end
      idle(k); step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avs_wait_mem.md
Name: avs_wait_mem

Overview:
- Avalon-MM slave memory. It is the responder end for the team's Avalon masters, including the DMA source and destination ports.
- Single-port word-addressed RAM with byte enables and a programmable number of waitrequest cycles per transfer.
- Used as DMA source/destination memory in system builds and as the slow-slave model in master verification.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 8, word-address width.
- DEPTH, 256, number of words implemented; must be ≤ 2**ADDR_W.
- WAIT_CYCLES, 2, waitrequest-high cycles per transfer; must be ≥ 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous reset, active-high.
- avs_s0_address  in  ADDR_W  word address.
- avs_s0_read  in  1  read request.
- avs_s0_write  in  1  write request.
- avs_s0_byteenable  in  DATA_W/8  write byte lanes.
- avs_s0_writedata  in  DATA_W  write data.
- avs_s0_readdata  out  DATA_W  read data; valid in the cycle waitrequest is low during a read.
- avs_s0_waitrequest  out  1  stall; combinational from request and state.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - FSM goes to IDLE, counter to 0, avs_s0_readdata to 0.
  - RAM contents are not cleared.
- Waitrequest: avs_s0_waitrequest = (read | write) & (state != ACK). It is 0 while no request is present.
- FSM states:
  - IDLE
    - A request (read or write) loads cnt = WAIT_CYCLES-1.
    - Next state is ACK if WAIT_CYCLES==1, else WAIT.
  - WAIT
    - If the request drops (protocol violation), go to IDLE; nothing is written and readdata is unchanged.
    - Else if cnt==1, go to ACK.
    - Else cnt decrements.
  - ACK
    - Waitrequest is 0 and the transfer completes this cycle.
    - A write commits here: for each lane i with byteenable[i]=1, mem[address][8i+7:8i] <= writedata lane i.
    - Next state is always IDLE.
- Readdata capture:
  - Registered from mem[address] on the edge that enters ACK.
  - Held until the next read capture.
- Latency: a request first asserted at cycle T completes at cycle T+WAIT_CYCLES (waitrequest low).
  - Back-to-back transfers cost WAIT_CYCLES+1 cycles each, because ACK returns to IDLE.
- Master obligation: hold address, byteenable, writedata and request stable while waitrequest is high. The slave samples address for reads at the ACK entry edge and for writes in ACK.
- Read and write both asserted (illegal): the transfer is treated as a write; readdata is not updated.
- Out of range (address ≥ DEPTH): the access completes with normal timing. Writes are dropped; reads capture 0.
- byteenable = 0 on a write: the transfer completes and memory is unchanged.
- Reset asserted in WAIT or ACK: the transfer is aborted and no write commits, including in ACK.
  - The next cycle is IDLE, with waitrequest following the request.

Decomposition:
- Shared package avalon_pkg:
  - slave FSM state enum {IDLE, WAIT, ACK};
  - byte-lane width constant 8;
  - helper function for the lane count DATA_W/8.
- Sub-module avs_ram_core: single-port synchronous RAM with a per-byte write enable and registered read port.
  - The FSM/counter stays in avs_wait_mem.

Test Plan:
- Single write then read, WAIT_CYCLES=2:
  - write 0xDEADBEEF to addr 0x05 with be=0xF → waitrequest high 2 cycles, low in cycle 3.
  - read 0x05 → readdata=0xDEADBEEF in the waitrequest-low cycle.
- Byte enables:
  - preload 0x11223344 at addr 0x10, then write 0xAABBCCDD with be=0x5 → a read returns 0x11BB33DD.
- WAIT_CYCLES=1 back-to-back: 4 reads of addrs 0–3 issued continuously → each completes 1 cycle after assertion, 2 cycles per transfer, data correct in order.
- Out of range, DEPTH=200:
  - write 0xFFFFFFFF to addr 0xF0 → completes normally;
  - read 0xF0 → 0x00000000;
  - addr 0x70 is unchanged.
- Reset mid-transfer, WAIT_CYCLES=4:
  - write 0x12345678 to 0x20; assert reset in wait cycle 2 → FSM to IDLE.
  - A later read of 0x20 returns the old value (no commit).
  - readdata reads 0 immediately after reset.
- Request dropped in WAIT, plus simultaneous read and write:
  - dropping read mid-wait → next request gets the full WAIT_CYCLES.
  - read=write=1 with data 0x0000CAFE at 0x01 → memory is written and readdata holds its prior value.
